seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive cycles an AN/seg pair must hold unchanged before it is sampled (range 1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: idle cycles with no digit capture before the partial frame is discarded (range 16..2^20-1).
REQ-003 clk  in  1  single clock; all logic is synchronous to its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 AN  in  4  digit anodes, active-low; one-hot-low selects digit 0..3 (AN[0] = digit 0).
REQ-006 seg  in  8  segments, active-low; seg[6:0] = g..a, seg[7] = dp.
REQ-007 value  out  16  last complete frame; digit n occupies value[4n+3:4n].
REQ-008 dp  out  4  decimal-point state per digit of the last frame, 1 = lit.
REQ-009 frame_valid  out  1  one-cycle pulse when value/dp/frame_err update.
REQ-010 frame_err  out  1  set with frame_valid when any digit of that frame was undecodable.
REQ-011 timeout  out  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-012 The block SHALL register AN and seg once and compare each registered pair with the previous one; any difference SHALL reload the stability counter to 0.
REQ-013 A pair SHALL be sampled exactly once, on the cycle its stability counter reaches STABLE_CYCLES-1, and only if AN is one-hot-low; AN = 4'b1111 or multi-low SHALL never be sampled.
REQ-014 Decode table (seg[6:0] with dp off): C0=0 F9=1 A4=2 B0=3 99=4 92=5 82=6 F8=7 80=8 90=9 88=A 83=b C6=C A1=d 86=E 8E=F; any other pattern SHALL decode to 0 and set the frame error flag.
REQ-015 A sample SHALL write shadow nibble, shadow dp and seen[n] for the selected digit; re-sampling an already-seen digit SHALL overwrite it without error.
REQ-016 FSM states: COLLECT (seen != 4'b1111), PUBLISH; the cycle after seen becomes 4'b1111 the block SHALL enter PUBLISH, copy shadow to value/dp, drive frame_valid = 1 and frame_err, clear seen and the error flag, and return to COLLECT.
REQ-017 Latency: frame_valid SHALL assert 2 cycles after the sampling cycle of the fourth distinct digit.
REQ-018 A sample arriving in the PUBLISH cycle SHALL be recorded into the next frame, not lost.
REQ-019 An idle counter SHALL increment every cycle without a sample and clear on a sample; at TIMEOUT_CYCLES it SHALL clear seen and the error flag, pulse timeout for one cycle, and leave value/dp unchanged.
REQ-020 The idle counter SHALL saturate, not wrap, and timeout SHALL pulse at most once per idle interval.

Reset
REQ-021 On rst_n low: value = 0, dp = 0, frame_valid = 0, frame_err = 0, timeout = 0, seen = 0, all counters 0, FSM = COLLECT, input registers = 8'hFF/4'hF.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame; no frame_valid SHALL follow reset release until four new digits are sampled.

Configuration
REQ-023 Macro SEG_SCAN_DP_EN: when defined, dp SHALL reflect ~seg[7] captured per digit and the decode SHALL ignore seg[7]; when undefined, dp SHALL be tied to 0 and any sample with seg[7] = 0 SHALL set the frame error flag.

Structure
REQ-024 Package seg_scan_pkg SHALL hold the 16 segment-code constants, the FSM state enum and the digit-count constant.
REQ-025 Combinational sub-module seg7_to_hex (seg[6:0] in, nibble + invalid out) SHALL implement REQ-014.

Verification
REQ-026 Scan digits 0..3 with seg C0,F9,A4,B0, each held 8 cycles -> frame_valid once, value = 16'h3210, frame_err = 0.
REQ-027 Digit 2 held only 3 cycles with STABLE_CYCLES = 4 -> no sample, no frame_valid until digit 2 is re-scanned for 4 cycles.
REQ-028 Digit 1 driven seg = 8'hFF -> frame_valid with frame_err = 1, value[7:4] = 0.
REQ-029 Scan 3 digits, then AN = 4'hF for TIMEOUT_CYCLES (set 16) -> timeout pulse on cycle 16, value unchanged, next frame needs all 4 digits.
REQ-030 With SEG_SCAN_DP_EN, digit 3 seg = 8'h06 (E, dp lit) -> value[15:12] = E, dp = 4'b1000; without the macro -> frame_err = 1, dp = 0.
REQ-031 rst_n pulsed low after 2 digits sampled -> all outputs 0; 2 further digits alone produce no frame_valid.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan decoder: segment codes, FSM states, digit count.
package seg_scan_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;

  // Active-low segment codes {dp, g..a} with the decimal point off
  localparam logic [7:0] SEG_HEX_0 = 8'hC0;
  localparam logic [7:0] SEG_HEX_1 = 8'hF9;
  localparam logic [7:0] SEG_HEX_2 = 8'hA4;
  localparam logic [7:0] SEG_HEX_3 = 8'hB0;
  localparam logic [7:0] SEG_HEX_4 = 8'h99;
  localparam logic [7:0] SEG_HEX_5 = 8'h92;
  localparam logic [7:0] SEG_HEX_6 = 8'h82;
  localparam logic [7:0] SEG_HEX_7 = 8'hF8;
  localparam logic [7:0] SEG_HEX_8 = 8'h80;
  localparam logic [7:0] SEG_HEX_9 = 8'h90;
  localparam logic [7:0] SEG_HEX_A = 8'h88;
  localparam logic [7:0] SEG_HEX_B = 8'h83;
  localparam logic [7:0] SEG_HEX_C = 8'hC6;
  localparam logic [7:0] SEG_HEX_D = 8'hA1;
  localparam logic [7:0] SEG_HEX_E = 8'h86;
  localparam logic [7:0] SEG_HEX_F = 8'h8E;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PUBLISH = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decode of an active-low seven-segment pattern (g..a) to a hex nibble.
module seg7_to_hex
  import seg_scan_pkg::*;
(
  input  logic [6:0]       seg,
  output logic [NIB_W-1:0] nibble,
  output logic             invalid
);

  logic [7:0] code;
  assign code = {1'b1, seg};

  always_comb begin
    nibble  = '0;
    invalid = 1'b0;
    case (code)
      SEG_HEX_0: nibble = 4'h0;
      SEG_HEX_1: nibble = 4'h1;
      SEG_HEX_2: nibble = 4'h2;
      SEG_HEX_3: nibble = 4'h3;
      SEG_HEX_4: nibble = 4'h4;
      SEG_HEX_5: nibble = 4'h5;
      SEG_HEX_6: nibble = 4'h6;
      SEG_HEX_7: nibble = 4'h7;
      SEG_HEX_8: nibble = 4'h8;
      SEG_HEX_9: nibble = 4'h9;
      SEG_HEX_A: nibble = 4'hA;
      SEG_HEX_B: nibble = 4'hB;
      SEG_HEX_C: nibble = 4'hC;
      SEG_HEX_D: nibble = 4'hD;
      SEG_HEX_E: nibble = 4'hE;
      SEG_HEX_F: nibble = 4'hF;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers a 4-digit hex value from a multiplexed seven-segment display scan.
// Optional macro SEG_SCAN_DP_EN captures per-digit decimal points; otherwise a lit dp is an error.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  AN,
  input  logic [7:0]  seg,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        timeout
);

  localparam int unsigned STAB_W = 8;
  localparam int unsigned IDLE_W = 20;

  logic [3:0]        an_q;
  logic [7:0]        seg_q;
  logic [STAB_W-1:0] stab_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [15:0]       shadow;
  logic [3:0]        shadow_dp;
  logic [3:0]        seen;
  logic              err_flag;
  scan_state_t       state;

  logic             digit_ok_c;
  logic [1:0]       digit_idx_c;
  logic [3:0]       digit_oh_c;
  logic [NIB_W-1:0] nibble_c;
  logic             invalid_c;
  logic             dp_bit_c;
  logic             bad_c;
  logic             sample_c;
  logic             timeout_hit_c;

  seg7_to_hex u_dec (
    .seg     (seg_q[6:0]),
    .nibble  (nibble_c),
    .invalid (invalid_c)
  );

  // Only a single active-low anode identifies a digit
  always_comb begin
    digit_ok_c  = 1'b1;
    digit_idx_c = 2'd0;
    digit_oh_c  = ~an_q;
    case (an_q)
      4'b1110: digit_idx_c = 2'd0;
      4'b1101: digit_idx_c = 2'd1;
      4'b1011: digit_idx_c = 2'd2;
      4'b0111: digit_idx_c = 2'd3;
      default: digit_ok_c  = 1'b0;
    endcase
  end

`ifdef SEG_SCAN_DP_EN
  assign dp_bit_c = ~seg_q[7];
  assign bad_c    = invalid_c;
`else
  assign dp_bit_c = 1'b0;
  assign bad_c    = invalid_c | ~seg_q[7];
`endif

  assign sample_c      = digit_ok_c && (stab_cnt == STAB_W'(STABLE_CYCLES - 1));
  assign timeout_hit_c = !sample_c && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q        <= 4'hF;
      seg_q       <= 8'hFF;
      stab_cnt    <= '0;
      idle_cnt    <= '0;
      shadow      <= '0;
      shadow_dp   <= '0;
      seen        <= '0;
      err_flag    <= 1'b0;
      state       <= ST_COLLECT;
      value       <= '0;
      dp          <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      an_q  <= AN;
      seg_q <= seg;

      // Counter saturates just past the sample point so a held pair is taken once
      if ({AN, seg} != {an_q, seg_q}) begin
        stab_cnt <= '0;
      end else if (stab_cnt != STAB_W'(STABLE_CYCLES)) begin
        stab_cnt <= stab_cnt + STAB_W'(1);
      end

      if (sample_c) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_W'(TIMEOUT_CYCLES)) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end

      if (sample_c) begin
        shadow[{digit_idx_c, 2'b00} +: NIB_W] <= nibble_c;
        shadow_dp[digit_idx_c]                <= dp_bit_c;
      end

      frame_valid <= 1'b0;
      timeout     <= timeout_hit_c;
      seen        <= seen | (sample_c ? digit_oh_c : 4'h0);
      err_flag    <= err_flag | (sample_c & bad_c);

      case (state)
        ST_COLLECT: begin
          // Publish the completed frame; a coincident sample starts the next one
          if (seen == 4'hF) begin
            state       <= ST_PUBLISH;
            value       <= shadow;
            dp          <= shadow_dp;
            frame_valid <= 1'b1;
            frame_err   <= err_flag;
            seen        <= sample_c ? digit_oh_c : 4'h0;
            err_flag    <= sample_c & bad_c;
          end
        end
        ST_PUBLISH: state <= ST_COLLECT;
        default:    state <= ST_COLLECT;
      endcase

      if (timeout_hit_c) begin
        seen     <= '0;
        err_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with hand-computed expected frames.
module tb_seg_scan_decoder;

  localparam int unsigned STABLE = 4;
  localparam int unsigned TMO    = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  AN;
  logic [7:0]  seg;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        frame_valid;
  logic        frame_err;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int fv_cnt = 0;
  int fv_cyc = 0;
  int to_cnt = 0;
  int to_cyc = 0;
  int last_set = 0;
  int base_fv;
  int base_to;
  int d_set;

  seg_scan_decoder #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .AN          (AN),
    .seg         (seg),
    .value       (value),
    .dp          (dp),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_valid === 1'b1) begin
        fv_cnt = fv_cnt + 1;
        fv_cyc = cyc;
      end
      if (timeout === 1'b1) begin
        to_cnt = to_cnt + 1;
        to_cyc = cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scan(input logic [3:0] an, input logic [7:0] sg, input int n);
    AN       = an;
    seg      = sg;
    last_set = cyc;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    scan(4'hF, 8'hFF, n);
  endtask

  task automatic frame(input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3);
    scan(4'b1110, s0, 8);
    scan(4'b1101, s1, 8);
    scan(4'b1011, s2, 8);
    scan(4'b0111, s3, 8);
  endtask

  initial begin
    rst_n = 1'b0;
    AN    = 4'hF;
    seg   = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_value", 32'(value), 32'h0);
    check_eq("rst_dp", 32'(dp), 32'h0);
    check_eq("rst_fv", 32'(frame_valid), 32'h0);
    check_eq("rst_ferr", 32'(frame_err), 32'h0);
    check_eq("rst_timeout", 32'(timeout), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // Basic frame and latency
    base_fv = fv_cnt;
    frame(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    d_set = last_set;
    idle(4);
    check_eq("basic_fv_count", 32'(fv_cnt - base_fv), 32'd1);
    check_eq("basic_value", 32'(value), 32'h3210);
    check_eq("basic_ferr", 32'(frame_err), 32'h0);
    check_eq("basic_dp", 32'(dp), 32'h0);
    check_eq("basic_latency", 32'(fv_cyc - d_set), 32'd6);

    // Digit 2 held too briefly is not sampled
    base_fv = fv_cnt;
    scan(4'b1110, 8'h99, 8);
    scan(4'b1101, 8'h92, 8);
    scan(4'b1011, 8'h82, 3);
    scan(4'b0111, 8'hF8, 8);
    idle(4);
    check_eq("short_hold_no_fv", 32'(fv_cnt - base_fv), 32'd0);
    scan(4'b1011, 8'h82, 4);
    idle(4);
    check_eq("rescan_fv_count", 32'(fv_cnt - base_fv), 32'd1);
    check_eq("rescan_value", 32'(value), 32'h7654);

    // Undecodable digit 1
    frame(8'h80, 8'hFF, 8'h90, 8'h88);
    idle(4);
    check_eq("bad_value", 32'(value), 32'hA908);
    check_eq("bad_nibble", 32'(value[7:4]), 32'h0);
    check_eq("bad_ferr", 32'(frame_err), 32'h1);

    // Clean frame clears the error
    frame(8'h83, 8'hC6, 8'hA1, 8'h8E);
    idle(4);
    check_eq("alpha_value", 32'(value), 32'hFDCB);
    check_eq("alpha_ferr", 32'(frame_err), 32'h0);

    // Decimal point on digit 3
    frame(8'h86, 8'hC0, 8'hC0, 8'h06);
    idle(4);
    check_eq("dp_value", 32'(value), 32'hE00E);
`ifdef SEG_SCAN_DP_EN
    check_eq("dp_bits", 32'(dp), 32'h8);
    check_eq("dp_ferr", 32'(frame_err), 32'h0);
`else
    check_eq("dp_bits", 32'(dp), 32'h0);
    check_eq("dp_ferr", 32'(frame_err), 32'h1);
`endif

    // Partial frame discarded by timeout
    base_fv = fv_cnt;
    base_to = to_cnt;
    scan(4'b1110, 8'hC0, 8);
    scan(4'b1101, 8'hF9, 8);
    scan(4'b1011, 8'hA4, 8);
    d_set = last_set;
    idle(40);
    check_eq("to_count", 32'(to_cnt - base_to), 32'd1);
    check_eq("to_cycle", 32'(to_cyc - d_set), 32'd21);
    check_eq("to_pulse_low", 32'(timeout), 32'h0);
    check_eq("to_value_kept", 32'(value), 32'hE00E);
    check_eq("to_no_fv", 32'(fv_cnt - base_fv), 32'd0);
    scan(4'b0111, 8'hB0, 8);
    idle(4);
    check_eq("to_one_digit_no_fv", 32'(fv_cnt - base_fv), 32'd0);
    scan(4'b1110, 8'hC0, 8);
    scan(4'b1101, 8'hF9, 8);
    scan(4'b1011, 8'hA4, 8);
    idle(4);
    check_eq("to_refill_fv", 32'(fv_cnt - base_fv), 32'd1);
    check_eq("to_refill_value", 32'(value), 32'h3210);

    // Reset mid-frame
    scan(4'b1110, 8'hC0, 8);
    scan(4'b1101, 8'hF9, 8);
    rst_n = 1'b0;
    AN    = 4'hF;
    seg   = 8'hFF;
    #1;
    check_eq("midrst_value", 32'(value), 32'h0);
    check_eq("midrst_dp", 32'(dp), 32'h0);
    check_eq("midrst_fv", 32'(frame_valid), 32'h0);
    check_eq("midrst_ferr", 32'(frame_err), 32'h0);
    check_eq("midrst_timeout", 32'(timeout), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base_fv = fv_cnt;
    scan(4'b1011, 8'hA4, 8);
    scan(4'b0111, 8'hB0, 8);
    idle(6);
    check_eq("midrst_no_fv", 32'(fv_cnt - base_fv), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
